cc_branch_ctrl: RTL and testbench
=================================

// Module: cc_branch_ctrl
// PURPOSE
//  Sequencer for the SLC3 condition-code path. Per instruction handshake it: classifies the opcode;
//  pulses LD_CC to the NZP flag register when a CC-setting result is on the bus; resolves BR
//  against the stored NZP; pulses LD_PC_BR on a taken branch. Sits between ISDU and NZP/PC regs.
// PARAMETERS
//  TIMEOUT  16  max cycles waited for Result_Valid before aborting with Err (>=2)
//  CNT_W    16  width of taken-branch statistics counter
// PORTS
//  Clk           in   1      clock, all state on posedge
//  Reset         in   1      asynchronous, active-high
//  Start         in   1      IR valid, begin sequencing (sampled only in IDLE)
//  IR            in   16     instruction; latched on accepted Start
//  NZP           in   3      current flag register contents {N,Z,P}
//  Result_Valid  in   1      datapath result valid on bus this cycle
//  LD_CC         out  1      load enable to NZP register (1-cycle pulse)
//  LD_PC_BR      out  1      load PC with branch target (1-cycle pulse)
//  BEN           out  1      branch-enable, valid in BR_EVAL, held until next Start
//  Busy          out  1      high in every state except IDLE
//  Done          out  1      1-cycle completion pulse
//  Err           out  1      timeout flag, valid with Done
//  Br_Taken_Cnt  out  CNT_W  count of taken branches, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; IR_q=0; BEN=0; Err=0; timer=0; Br_Taken_Cnt=0; all pulses 0. Reset mid-
//   sequence aborts immediately, no Done, no LD_CC/LD_PC_BR.
//  States: IDLE, DECODE, WAIT_RES, BR_EVAL, BR_TAKE, FINISH.
//  IDLE: Start=1 -> latch IR_q, clear Err/timer -> DECODE. Start ignored in all other states.
//  DECODE: op=IR_q[15:12]. CC-setting {ADD 0001, AND 0101, NOT 1001, LD 0010, LDI 1010,
//   LDR 0110, LEA 1110} -> WAIT_RES; BR 0000 -> BR_EVAL; all others -> FINISH.
//  WAIT_RES: LD_CC = Result_Valid (Mealy, same edge NZP reg captures) -> FINISH when set.
//   Timer increments each cycle without Result_Valid; at timer==TIMEOUT-1 with no Result_Valid
//   -> FINISH with Err=1, no LD_CC. Result_Valid on that last cycle wins (no Err).
//  BR_EVAL: BEN <= |(IR_q[11:9] & NZP); taken -> BR_TAKE else FINISH. nzp=000 or NZP=000
//   (post-reset) is never taken; nzp=111 always taken if NZP!=000.
//  BR_TAKE: LD_PC_BR=1; Br_Taken_Cnt+1 (modulo 2^CNT_W) -> FINISH.
//  FINISH: Done=1 -> IDLE. Start in FINISH ignored; may be accepted next cycle in IDLE.
//  Latency (Start at edge T): other op Done @T+2; BR not taken Done @T+3; BR taken LD_PC_BR
//   @T+3, Done @T+4; CC op, Result_Valid k cycles into WAIT_RES: LD_CC @T+2+k, Done @T+3+k.
//  LD_CC, LD_PC_BR, Done never asserted together; Busy=0 only in IDLE.
//  NZP sampled only in BR_EVAL; changes elsewhere have no effect.
// STRUCTURE
//  Package slc3_ctrl_pkg: opcode localparams (OP_BR, OP_ADD, ...), state enum
//   cc_state_t, function is_cc_op(op[3:0]). Single always_ff for state/regs, always_comb for
//   next-state and outputs. No sub-module; timer and counter are inline.
// TESTING
//  1 ADD x1234 Start, Result_Valid 2 cycles later -> LD_CC one cycle then, Done next, Err=0.
//  2 BR nzp=010 with NZP=010 -> BEN=1, LD_PC_BR @T+3, Done @T+4, Br_Taken_Cnt 0->1.
//  3 BR nzp=101 with NZP=010 -> BEN=0, no LD_PC_BR, Done @T+3, counter unchanged.
//  4 LDR, Result_Valid never, TIMEOUT=16 -> Done with Err=1 @T+2+16, LD_CC never asserted.
//  5 JMP (1100) -> Done @T+2, no LD_CC/LD_PC_BR; Start held high while Busy -> one Done only.
//  6 Reset asserted in WAIT_RES -> Busy=0 immediately, no Done; BR after reset (NZP=000) untaken.

Source files
------------

// File: rtl/slc3_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slc3_ctrl_pkg : opcodes, sequencer states, CC-op classifier  rev 1.0 |
// +----------------------------------------------------------------------+
package slc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_BR_EVAL  = 3'd3,
    ST_BR_TAKE  = 3'd4,
    ST_FINISH   = 3'd5
  } cc_state_t;

  function automatic logic is_cc_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LD) ||
           (op == OP_LDI) || (op == OP_LDR) || (op == OP_LEA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cc_branch_ctrl : SLC3 condition-code / branch sequencer      rev 1.0 |
// +----------------------------------------------------------------------+
module cc_branch_ctrl
  import slc3_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [15:0]      IR,
  input  logic [2:0]       NZP,
  input  logic             Result_Valid,
  output logic             LD_CC,
  output logic             LD_PC_BR,
  output logic             BEN,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [CNT_W-1:0] Br_Taken_Cnt
);

  localparam int              c_tw         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_tw-1:0] c_timer_last = c_tw'(TIMEOUT - 1);

  cc_state_t        r_state;
  cc_state_t        w_next;
  logic [15:0]      r_ir;
  logic             r_ben;
  logic             r_err;
  logic [c_tw-1:0]  r_timer;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_taken;
  logic             w_ld_cc;
  logic             w_ld_pc;
  logic             w_done;
  logic             w_err_set;
  logic             w_timer_inc;
  logic             w_unused_ir;

  // Only the opcode and the nzp condition field steer this sequencer.
  assign w_unused_ir = ^r_ir[8:0];
  assign w_taken     = |(r_ir[11:9] & NZP);

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_ld_cc     = 1'b0;
    w_ld_pc     = 1'b0;
    w_done      = 1'b0;
    w_err_set   = 1'b0;
    w_timer_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_cc_op(r_ir[15:12]))    w_next = ST_WAIT_RES;
        else if (r_ir[15:12] == OP_BR) w_next = ST_BR_EVAL;
        else                           w_next = ST_FINISH;
      end
      ST_WAIT_RES: begin
        // A result arriving on the final allowed cycle still counts as success.
        if (Result_Valid) begin
          w_ld_cc = 1'b1;
          w_next  = ST_FINISH;
        end else if (r_timer == c_timer_last) begin
          w_err_set = 1'b1;
          w_next    = ST_FINISH;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      ST_BR_EVAL: w_next = w_taken ? ST_BR_TAKE : ST_FINISH;
      ST_BR_TAKE: begin
        w_ld_pc = 1'b1;
        w_next  = ST_FINISH;
      end
      ST_FINISH: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_ben   <= 1'b0;
      r_err   <= 1'b0;
      r_timer <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ir    <= IR;
        r_ben   <= 1'b0;
        r_err   <= 1'b0;
        r_timer <= '0;
      end
      if (r_state == ST_BR_EVAL) r_ben   <= w_taken;
      if (w_err_set)             r_err   <= 1'b1;
      if (w_timer_inc)           r_timer <= r_timer + 1'b1;
      if (w_ld_pc)               r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign LD_CC        = w_ld_cc;
  assign LD_PC_BR     = w_ld_pc;
  assign Done         = w_done;
  assign Busy         = (r_state != ST_IDLE);
  assign BEN          = r_ben;
  assign Err          = r_err;
  assign Br_Taken_Cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cc_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cc_branch_ctrl : latency/flag reference model bench       rev 1.0 |
// +----------------------------------------------------------------------+
module tb_cc_branch_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic [15:0]      IR;
  logic [2:0]       NZP;
  logic             Result_Valid;
  logic             LD_CC;
  logic             LD_PC_BR;
  logic             BEN;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic [CNT_W-1:0] Br_Taken_Cnt;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] m_cnt    = '0;

  cc_branch_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR(IR), .NZP(NZP),
    .Result_Valid(Result_Valid), .LD_CC(LD_CC), .LD_PC_BR(LD_PC_BR), .BEN(BEN),
    .Busy(Busy), .Done(Done), .Err(Err), .Br_Taken_Cnt(Br_Taken_Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour is derived from the opcode class and the latency table:
  // j counts negedges after the accepting edge T, so j sees the "@T+j+1" cycle.
  task automatic run_op(input logic [15:0] ir, input logic [2:0] nzp, input int k, input bit noise);
    logic [3:0] op;
    bit cc, isbr, taken, exp_err, in_wait;
    int rv_j, done_j;
    op      = ir[15:12];
    cc      = op inside {4'd1, 4'd5, 4'd9, 4'd2, 4'd10, 4'd6, 4'd14};
    isbr    = (op == 4'd0);
    taken   = isbr && ((ir[11:9] & nzp) != 3'b000);
    rv_j    = (cc && k >= 0 && k < TIMEOUT) ? k + 1 : -1;
    done_j  = cc ? ((rv_j > 0) ? k + 2 : TIMEOUT + 1) : (isbr ? (taken ? 3 : 2) : 1);
    exp_err = cc && (rv_j < 0);

    Start        = 1'b1;
    IR           = ir;
    NZP          = 3'($urandom);
    Result_Valid = noise ? 1'($urandom) : 1'b0;
    @(posedge Clk);
    for (int j = 0; j <= done_j; j++) begin
      @(negedge Clk);
      in_wait      = cc && (j >= 1) && (j < done_j);
      Start        = noise ? 1'($urandom) : 1'b0;
      IR           = noise ? 16'($urandom) : ir;
      NZP          = (j == 1 || !noise) ? nzp : 3'($urandom);
      Result_Valid = (j == rv_j) ? 1'b1 : (in_wait ? 1'b0 : (noise ? 1'($urandom) : 1'b0));
      #1;
      if (taken && j == 3) m_cnt = m_cnt + 1'b1;
      check("busy",  32'(Busy),     32'd1);
      check("ld_cc", 32'(LD_CC),    32'(j == rv_j));
      check("ld_pc", 32'(LD_PC_BR), 32'(taken && j == 2));
      check("done",  32'(Done),     32'(j == done_j));
      if (j == done_j) begin
        check("err", 32'(Err), 32'(exp_err));
        check("cnt", 32'(Br_Taken_Cnt), 32'(m_cnt));
        if (isbr) check("ben", 32'(BEN), 32'(taken));
      end
    end
    @(negedge Clk);
    Start        = 1'b0;
    Result_Valid = 1'b0;
    #1;
    check("idle_busy", 32'(Busy), 32'd0);
    check("idle_done", 32'(Done), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; IR = '0; NZP = '0; Result_Valid = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ben",  32'(BEN),  32'd0);
    check("rst_err",  32'(Err),  32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_cnt",  32'(Br_Taken_Cnt), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run_op(16'h1234, 3'b000, 2, 1'b0);               // ADD, result 2 cycles in
    run_op(16'h0400, 3'b010, 0, 1'b0);               // BR z, taken
    run_op(16'h0A00, 3'b010, 0, 1'b0);               // BR np, not taken
    run_op(16'h6000, 3'b000, -1, 1'b0);              // LDR timeout
    run_op(16'h5000, 3'b000, TIMEOUT - 1, 1'b0);     // result on last allowed cycle
    run_op(16'hE000, 3'b000, 0, 1'b1);               // LEA immediate result
    run_op(16'hC000, 3'b000, 0, 1'b1);               // JMP with Start noise
    run_op(16'h0E00, 3'b001, 0, 1'b1);               // BR nzp, taken
    run_op(16'h0000, 3'b111, 0, 1'b1);               // BR no condition bits

    for (int i = 0; i < 40; i++)
      run_op(16'($urandom), 3'($urandom), int'($urandom_range(0, 20)), 1'b1);

    // Reset in the middle of WAIT_RES
    Start = 1'b1; IR = 16'h2000;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1; Result_Valid = 1'b1;
    #1;
    m_cnt = '0;
    check("midrst_busy", 32'(Busy),  32'd0);
    check("midrst_done", 32'(Done),  32'd0);
    check("midrst_ldcc", 32'(LD_CC), 32'd0);
    check("midrst_cnt",  32'(Br_Taken_Cnt), 32'd0);
    @(negedge Clk);
    Reset = 1'b0; Result_Valid = 1'b0;
    run_op(16'h0E00, 3'b000, 0, 1'b0);               // BR nzp with flags cleared

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
